// File: rtl/arb_pkg.sv
// Shared types, default widths and the round-robin pick function for the
// shared-register write arbiter.
package arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 16;
  localparam int MAX_REQ   = 8;
  localparam int OWNER_W   = 3;
  localparam int COUNT_W   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // First set bit of req, searching upward from last+1 and wrapping at n.
  // Only meaningful when at least one of req[n-1:0] is set.
  function automatic logic [OWNER_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [OWNER_W-1:0] last,
    input int                 n
  );
    logic [OWNER_W-1:0] sel;
    logic               found;
    int                 idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      idx = (int'(last) + k) % n;
      if (!found && k <= n && req[idx]) begin
        sel   = OWNER_W'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/data_register.sv
// Load-enabled shared storage word; holds its value whenever load is low.
module data_register
  import arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  // NOTE: a single word is reset on purpose; a reset abort must leave 0 here.
  // Deep storage arrays would normally be left unreset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter committing one requester's word (or a clear) into a
// shared register every three cycles: IDLE grants, WRITE loads, ACK reports.
module reg_write_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic                   clr,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       rdata,
  output logic [OWNER_W-1:0]     owner,
  output logic [COUNT_W-1:0]     wr_count,
  output logic                   busy
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t             state;
  logic [OWNER_W-1:0] last_winner;
  logic [OWNER_W-1:0] winner;
  logic               is_clr;
  logic [WIDTH-1:0]   latched;
  logic [MAX_REQ-1:0] req_ext;
  logic [OWNER_W-1:0] pick;
  logic               load;

  // NOTE: always_comb assigns a default before the partial write so no latch
  // is inferred for the unused upper bits.
  always_comb begin
    req_ext          = '0;
    req_ext[N_REQ-1:0] = req;
  end

  assign pick = rr_pick(req_ext, last_winner, N_REQ);
  assign load = (state == WRITE);

  // NOTE: all state below uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_winner <= OWNER_W'(N_REQ - 1);
      winner      <= '0;
      is_clr      <= 1'b0;
      latched     <= '0;
      ack         <= '0;
      owner       <= '0;
      wr_count    <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (clr) begin
            // A clear leaves the round-robin pointer untouched.
            is_clr  <= 1'b1;
            winner  <= '0;
            latched <= '0;
            state   <= WRITE;
            busy    <= 1'b1;
          end else if (|req) begin
            is_clr  <= 1'b0;
            winner  <= pick;
            latched <= wdata[int'(pick)*WIDTH +: WIDTH];
            state   <= WRITE;
            busy    <= 1'b1;
          end
        end
        WRITE: begin
          ack   <= is_clr ? '0 : (ONE_HOT0 << winner);
          state <= ACK;
        end
        ACK: begin
          ack      <= '0;
          owner    <= is_clr ? '0 : winner;
          wr_count <= wr_count + COUNT_W'(1);
          if (!is_clr) begin
            last_winner <= winner;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          ack   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  data_register #(.WIDTH(WIDTH)) u_data_register (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .data_in  (latched),
    .data_out (rdata)
  );

endmodule
